audrec_capture: RTL and testbench

Recording-path capture engine. Deserialises the WM8731 ADC I2S stream into 16-bit samples and issues one-cycle SRAM write strobes at an incrementing address. It sits beside the playback path inside `Top`, on the same 12 MHz system clock, and is the receive-direction counterpart of the DAC serialiser. Codec pins are oversampled, so the block has no second clock domain.

---
 rtl/audrec_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_audrec_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audrec_capture.sv
// audrec_capture: recording-path capture engine.
// Oversamples the WM8731 ADC I2S pins on the system clock, deserialises one DATA_W-bit sample
// per LRCK frame and emits a one-cycle SRAM write strobe at an incrementing word address.
//
// Ports:
//   i_clk, i_rst_n                      system clock, async active-low reset
//   i_start, i_pause, i_stop            one-cycle control pulses (stop > pause > start)
//   i_AUD_BCLK/ADCLRCK/ADCDAT           asynchronous codec pins
//   o_address, o_data, o_wr_en          SRAM write port (strobe is one cycle per sample)
//   o_busy                              high whenever the engine is not idle
//   o_full                              sticky, set by the write to MAX_ADDR
//   o_last_addr                         address of the most recent write
//
// Configuration macro: AUDREC_MONO_MIX_EN -- when defined, the right channel is also captured
// and the stored sample is the arithmetic mean (L + R) >>> 1; otherwise left channel only.

module audrec_capture #(
  parameter int unsigned            DATA_W   = 16,
  parameter int unsigned            ADDR_W   = 20,
  parameter logic [ADDR_W-1:0]      MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_last_addr
);

  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle, StWaitFrame, StSkip, StShift, StWrite, StPaused
  } state_e;

  // [1] is the synchronised value, [2] the one-cycle-older copy used for edge detection
  logic [2:0]        bclk_d, bclk_q, lrck_d, lrck_q;
  logic [1:0]        dat_d, dat_q;
  state_e            state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic [DATA_W-1:0] sr_d, sr_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W-1:0] address_d, address_q;
  logic [ADDR_W-1:0] last_addr_d, last_addr_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              wr_en_d, wr_en_q;
  logic              full_d, full_q;

  logic              bclk_rise, lrck_fall, frame_edge, abort;
  logic [DATA_W-1:0] sr_shift, sample;

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lrck_fall = ~lrck_q[1] & lrck_q[2];
  assign sr_shift  = {sr_q[DATA_W-2:0], dat_q[1]};
  assign abort     = i_stop | i_pause;

`ifdef AUDREC_MONO_MIX_EN
  // chan_q: 0 while collecting the left word, 1 while collecting the right word
  logic              chan_d, chan_q;
  logic [DATA_W-1:0] left_d, left_q;
  logic [DATA_W:0]   mix_sum;
  logic              lrck_rise;

  assign lrck_rise  = lrck_q[1] & ~lrck_q[2];
  assign frame_edge = chan_q ? lrck_rise : lrck_fall;
  // Sign-extend both words so the sum cannot overflow, then drop the LSB (arithmetic >>> 1)
  assign mix_sum    = {left_q[DATA_W-1], left_q} + {sr_shift[DATA_W-1], sr_shift};
  assign sample     = mix_sum[DATA_W:1];
`else
  assign frame_edge = lrck_fall;
  assign sample     = sr_shift;
`endif

  always_comb begin
    bclk_d      = {bclk_q[1:0], i_AUD_BCLK};
    lrck_d      = {lrck_q[1:0], i_AUD_ADCLRCK};
    dat_d       = {dat_q[0], i_AUD_ADCDAT};
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    addr_d      = addr_q;
    address_d   = address_q;
    last_addr_d = last_addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    full_d      = full_q;
`ifdef AUDREC_MONO_MIX_EN
    chan_d      = chan_q;
    left_d      = left_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start && !abort) begin
          state_d = StWaitFrame;
          addr_d  = '0;
          full_d  = 1'b0;
`ifdef AUDREC_MONO_MIX_EN
          chan_d  = 1'b0;
`endif
        end
      end
      StWaitFrame: begin
        if (!abort && frame_edge) state_d = StSkip;
      end
      StSkip: begin
        // I2S: the first BCLK rise after the LRCK edge carries no data
        if (!abort && bclk_rise) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (!abort && bclk_rise) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_W - 1)) begin
`ifdef AUDREC_MONO_MIX_EN
            if (!chan_q) begin
              left_d  = sr_shift;
              chan_d  = 1'b1;
              state_d = StWaitFrame;
            end else begin
`endif
              state_d     = StWrite;
              wr_en_d     = 1'b1;
              data_d      = sample;
              address_d   = addr_q;
              last_addr_d = addr_q;
`ifdef AUDREC_MONO_MIX_EN
            end
`endif
          end
        end
      end
      StWrite: begin
        // Control pulses seen here act only after the write has gone out
`ifdef AUDREC_MONO_MIX_EN
        chan_d = 1'b0;
`endif
        if (addr_q == MAX_ADDR) begin
          full_d  = 1'b1;
          state_d = StIdle;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (i_stop)       state_d = StIdle;
          else if (i_pause) state_d = StPaused;
          else              state_d = StWaitFrame;
        end
      end
      StPaused: begin
        if (i_stop)                  state_d = StIdle;
        else if (i_pause || i_start) state_d = StWaitFrame;
      end
      default: state_d = StIdle;
    endcase

    // Stop/pause while collecting a frame throws the partial frame away; addr is kept
    if (abort && (state_q inside {StWaitFrame, StSkip, StShift})) begin
      state_d = i_stop ? StIdle : StPaused;
`ifdef AUDREC_MONO_MIX_EN
      chan_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_q      <= '0;
      lrck_q      <= '0;
      dat_q       <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      addr_q      <= '0;
      address_q   <= '0;
      last_addr_q <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      full_q      <= 1'b0;
`ifdef AUDREC_MONO_MIX_EN
      chan_q      <= 1'b0;
      left_q      <= '0;
`endif
    end else begin
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      dat_q       <= dat_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      address_q   <= address_d;
      last_addr_q <= last_addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      full_q      <= full_d;
`ifdef AUDREC_MONO_MIX_EN
      chan_q      <= chan_d;
      left_q      <= left_d;
`endif
    end
  end

  assign o_address   = address_q;
  assign o_data      = data_q;
  assign o_wr_en     = wr_en_q;
  assign o_busy      = (state_q != StIdle);
  assign o_full      = full_q;
  assign o_last_addr = last_addr_q;

endmodule

// File: tb/tb_audrec_capture.sv
// Bench for audrec_capture: drives I2S frames on the codec pins, collects write strobes and
// checks them against a fixed vector table, hand-built corner sequences and a transaction-level
// recorder model under random frames and control pulses. DUT built with MAX_ADDR = 3.

module tb_audrec_capture;

  localparam int unsigned MaxA = 3;
  localparam int          Half = 20;  // BCLK slots per LRCK half-frame

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic        bclk = 1'b1, lrck = 1'b1, dat = 1'b0;
  logic [19:0] o_address, o_last_addr;
  logic [15:0] o_data;
  logic        o_wr_en, o_busy, o_full;

  always #5 clk = ~clk;

  audrec_capture #(
    .DATA_W  (16),
    .ADDR_W  (20),
    .MAX_ADDR(20'd3)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_pause      (pause),
    .i_stop       (stop),
    .i_AUD_BCLK   (bclk),
    .i_AUD_ADCLRCK(lrck),
    .i_AUD_ADCDAT (dat),
    .o_address    (o_address),
    .o_data       (o_data),
    .o_wr_en      (o_wr_en),
    .o_busy       (o_busy),
    .o_full       (o_full),
    .o_last_addr  (o_last_addr)
  );

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
    logic [19:0] la;
  } strobe_t;

  strobe_t act_q[$];
  always @(negedge clk) if (o_wr_en === 1'b1) act_q.push_back(strobe_t'({o_address, o_data, o_last_addr}));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Recorder model: recording on/off, paused, full, next address, expected strobe
  bit          m_rec = 0, m_paused = 0, m_full = 0;
  int unsigned m_addr = 0;
  int          exp_n, got_n;
  strobe_t     exp_s, got_s;

  function automatic logic [15:0] ref_sample(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDREC_MONO_MIX_EN
    int s;
    s = (int'($signed(l)) + int'($signed(r))) >>> 1;
    return s[15:0];
`else
    return l;
`endif
  endfunction

  function automatic void model_pulse(input bit s, input bit p, input bit t);
    if (t) begin
      m_rec = 0; m_paused = 0;
    end else if (p) begin
      if (m_rec) m_paused = !m_paused;
    end else if (s) begin
      if (!m_rec) begin
        m_rec = 1; m_paused = 0; m_addr = 0; m_full = 0;
      end else if (m_paused) m_paused = 0;
    end
  endfunction

  task automatic pulse(input bit s, input bit p, input bit t);
    @(negedge clk);
    start = s; pause = p; stop = t;
    model_pulse(s, p, t);
    @(negedge clk);
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  // kind: 0 none, 1 pause, 2 stop+pause, 3 reset pulse -- applied at left slot 9 (mid-word)
  task automatic send_half(input logic lr, input logic [15:0] w, input int kind);
    for (int k = 0; k < Half; k++) begin
      bclk = 1'b0;
      lrck = lr;
      dat  = (k >= 1 && k <= 16) ? w[16-k] : 1'($urandom);
      if (kind != 0 && k == 9) begin
        if (kind == 1) pause = 1'b1;
        if (kind == 2) begin pause = 1'b1; stop = 1'b1; end
        if (kind == 3) rst_n = 1'b0;
        #10;
        pause = 1'b0; stop = 1'b0; rst_n = 1'b1;
        #30;
      end else #40;
      bclk = 1'b1;
      #40;
    end
  endtask

  task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input int kind);
    bit cap;
    cap = m_rec && !m_paused;
    if (kind == 1) begin
      if (m_rec) m_paused = !m_paused;
      cap = 0;
    end else if (kind == 2) begin
      m_rec = 0; m_paused = 0; cap = 0;
    end else if (kind == 3) begin
      m_rec = 0; m_paused = 0; m_full = 0; m_addr = 0; cap = 0;
    end
    exp_n = 0;
    if (cap) begin
      exp_n = 1;
      exp_s = strobe_t'({20'(m_addr), ref_sample(l, r), 20'(m_addr)});
      if (m_addr == MaxA) begin
        m_full = 1; m_rec = 0;
      end else m_addr++;
    end
    act_q.delete();
    @(negedge clk);
    send_half(1'b0, l, kind);
    send_half(1'b1, r, 0);
    repeat (4) @(negedge clk);
    got_n = act_q.size();
    got_s = (got_n > 0) ? act_q[0] : '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " strobes"}, 64'(got_n), 64'(exp_n));
    if (exp_n == 1 && got_n == 1) begin
      chk({tag, " addr"}, 64'(got_s.a), 64'(exp_s.a));
      chk({tag, " data"}, 64'(got_s.d), 64'(exp_s.d));
      chk({tag, " last_addr"}, 64'(got_s.la), 64'(exp_s.la));
    end
    chk({tag, " busy"}, 64'(o_busy), 64'(m_rec));
    chk({tag, " full"}, 64'(o_full), 64'(m_full));
  endtask

  typedef struct {
    bit          restart;
    logic [15:0] l, r;
    bit          wr;
    logic [19:0] a;
    logic [15:0] dl, dm;  // expected data: left-only build, mono-mix build
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 16'hA5C3, 16'h0000, 1, 20'd0, 16'hA5C3, 16'hD2E1};
    tbl[1] = '{1, 16'h0001, 16'hFFFF, 1, 20'd0, 16'h0001, 16'h0000};
    tbl[2] = '{0, 16'h0002, 16'hFFFF, 1, 20'd1, 16'h0002, 16'h0000};
    tbl[3] = '{0, 16'h0003, 16'hFFFF, 1, 20'd2, 16'h0003, 16'h0001};
    tbl[4] = '{0, 16'h0004, 16'hFFFF, 1, 20'd3, 16'h0004, 16'h0001};
    tbl[5] = '{0, 16'h0005, 16'hFFFF, 0, 20'd0, 16'h0000, 16'h0000};
    tbl[6] = '{1, 16'h7FFF, 16'h0001, 1, 20'd0, 16'h7FFF, 16'h4000};
    tbl[7] = '{0, 16'h8000, 16'h8000, 1, 20'd1, 16'h8000, 16'h8000};

    // Reset: frame on the pins while held in reset produces nothing, all outputs zero
    act_q.delete();
    @(negedge clk);
    send_half(1'b0, 16'h1234, 0);
    send_half(1'b1, 16'h5678, 0);
    chk("strobes in reset", 64'(act_q.size()), 64'd0);
    chk("outputs in reset", 64'({o_wr_en, o_busy, o_full, o_address, o_data, o_last_addr}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("outputs after reset", 64'({o_wr_en, o_busy, o_full, o_address, o_data, o_last_addr}),
        64'd0);

    run_frame(16'hBEEF, 16'h1111, 0);
    check_model("no start");

    foreach (tbl[i]) begin
      if (tbl[i].restart) begin
        pulse(0, 0, 1);
        pulse(1, 0, 0);
      end
      run_frame(tbl[i].l, tbl[i].r, 0);
      chk($sformatf("vec%0d strobes", i), 64'(got_n), 64'(tbl[i].wr));
      if (tbl[i].wr && got_n == 1) begin
        chk($sformatf("vec%0d addr", i), 64'(got_s.a), 64'(tbl[i].a));
`ifdef AUDREC_MONO_MIX_EN
        chk($sformatf("vec%0d data", i), 64'(got_s.d), 64'(tbl[i].dm));
`else
        chk($sformatf("vec%0d data", i), 64'(got_s.d), 64'(tbl[i].dl));
`endif
        chk($sformatf("vec%0d last_addr", i), 64'(got_s.la), 64'(tbl[i].a));
      end
      if (i == 5) begin
        chk("full flag", 64'(o_full), 64'd1);
        chk("busy when full", 64'(o_busy), 64'd0);
      end
    end

    // Pause mid-word discards the frame; resume continues at the held address
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    run_frame(16'(
$urandom), 16'($urandom), 0);
    check_model("pause f1");
    run_frame(16'h3C3C, 16'($urandom), 1);
    check_model("pause f2");
    pulse(0, 1, 0);
    run_frame(16'h0F0F, 16'($urandom), 0);
    check_model("pause f3");
    chk("resume addr", 64'(got_s.a), 64'd1);

    // Stop with pause in the same cycle during SHIFT: idle, last address held, restart at 0
    run_frame(16'h5A5A, 16'($urandom), 2);
    check_model("stop prio");
    chk("stop last_addr", 64'(o_last_addr), 64'd1);
    pulse(1, 0, 0);
    run_frame(16'h1357, 16'($urandom), 0);
    check_model("after stop");
    chk("after stop addr", 64'(got_s.a), 64'd0);

    // Reset mid-frame
    run_frame(16'h2468, 16'($urandom), 3);
    check_model("reset mid");
    chk("outputs after mid reset",
        64'({o_wr_en, o_busy, o_full, o_address, o_data, o_last_addr}), 64'd0);

    // Random frames and control pulses against the model
    for (int it = 0; it < 40; it++) begin
      int sel, kind;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) pulse(1, 0, 0);
      else if (sel == 1) pulse(0, 1, 0);
      else if (sel == 2) pulse(0, 0, 1);
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_frame(16'($urandom), 16'($urandom), kind);
      check_model($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
